mips_mem_arbiter: RTL and testbench
===================================

# mips_mem_arbiter

Two-requester arbiter sharing the single-port unified memory between instruction fetch (IF) and data memory access (DM) in `mips_processor`. It accepts request/grant handshakes from both ports and issues exactly one memory access at a time. It tracks the fixed read latency and returns read data or a write acknowledgment to the port that owns the access. Data accesses take priority over fetch, with optional starvation protection for fetch.

## Interface
- `ADDR_WIDTH`, 32, memory address width
- `DATA_WIDTH`, 16, memory data width
- `MEM_LATENCY`, 1, cycles from `mem_en` to valid `mem_rdata`; legal range 1–7
- `STARVE_LIMIT`, 4, consecutive DM grants tolerated while IF waits; used only with the guard macro; legal range 1–15

- `clk`  in  1  system clock, rising-edge
- `rst_n`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request
- `if_addr`  in  ADDR_WIDTH  fetch address
- `if_gnt`  out  1  fetch grant, one-cycle pulse
- `if_rvalid`  out  1  fetch data valid, one-cycle pulse
- `if_rdata`  out  DATA_WIDTH  fetch data
- `dm_req`  in  1  data request
- `dm_we`  in  1  1 = write, 0 = read
- `dm_addr`  in  ADDR_WIDTH  data address
- `dm_wdata`  in  DATA_WIDTH  write data
- `dm_gnt`  out  1  data grant, one-cycle pulse
- `dm_rvalid`  out  1  read data valid or write done, one-cycle pulse
- `dm_rdata`  out  DATA_WIDTH  read data
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_WIDTH  memory address
- `mem_wdata`  out  DATA_WIDTH  memory write data
- `mem_rdata`  in  DATA_WIDTH  memory read data
- `busy`  out  1  access outstanding

## Operation
- **FSM states**
  - IDLE: no access outstanding.
  - WAIT: latency counter running; owner register holds IF or DM.
- **Arbitration**
  - Arbitration runs in IDLE, and also in the WAIT cycle in which the response completes.
  - Winner receives `gnt`=1 for that cycle.
  - In the same cycle, `mem_en`=1 and `mem_addr`/`mem_we`/`mem_wdata` are driven combinationally from the winner. IF accesses force `mem_we`=0.
- **Priority:** DM beats IF when both request.
- **Request handshake**
  - Requester holds `req`, address and write data stable until it sees `gnt`.
  - `req` still high in the cycle after `gnt` is a new request.
- **Grant:** latency counter loads `MEM_LATENCY`-1, owner is recorded, and the FSM goes to WAIT.
- **Response**
  - Issued when the counter reaches 0.
  - Owner's `rvalid`=1 for one cycle, with `rdata` equal to `mem_rdata` for reads; `dm_rdata`=0 for writes.
  - If a request is pending in the response cycle, it is granted in that same cycle and WAIT continues. Otherwise the FSM returns to IDLE.
- **Idle outputs:** when no grant is active, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- **`busy`:** 1 in WAIT, 0 in IDLE.
- **Non-owner `rdata`:** holds its last value; it changes only on that port's `rvalid`.

## Timing
- **Reset values:** all outputs are 0, FSM is IDLE, counters and `rdata` registers are 0.
- **Latency:** grant in cycle N gives `rvalid` in cycle N+`MEM_LATENCY`.
- **Throughput:** one access every `MEM_LATENCY` cycles under back-to-back requests.
- **Simultaneous `if_req` and `dm_req`:** DM is granted; IF waits. `if_gnt` and `dm_gnt` are never both 1.
- **Request during WAIT before the response cycle:** no grant; the request stays pending.
- **Reset mid-access:** the outstanding access is discarded, no `rvalid` is issued, and the FSM returns to IDLE.
- **Counter behaviour:** the latency counter never wraps; at 0 it either reloads on a new grant or the FSM exits.

## Configuration
- **Macro:** `MIPS_ARB_STARVE_GUARD_EN`.
- **Defined:**
  - A 4-bit counter increments on each DM grant while `if_req`=1.
  - The counter clears on an IF grant or when `if_req`=0.
  - When the counter equals `STARVE_LIMIT`, the next arbitration grants IF even if `dm_req`=1.
- **Undefined:** strict DM priority; IF may starve indefinitely; no counter logic.

## Test plan
- **Reset, then single IF read:** with `MEM_LATENCY`=1, assert `if_req` with `if_addr`=0x10 and `mem_rdata`=0xBEEF. Required: `if_gnt` and `mem_en` in cycle 0, `if_rvalid` with `if_rdata`=0xBEEF in cycle 1.
- **DM write:** `dm_we`=1, `dm_addr`=0x20, `dm_wdata`=0x1234. Required: `mem_we`=1, `mem_addr`=0x20, `mem_wdata`=0x1234 in the grant cycle, then `dm_rvalid`=1 with `dm_rdata`=0.
- **Simultaneous requests:** DM is granted first; IF is granted in DM's response cycle; `if_rvalid` arrives `MEM_LATENCY` cycles later.
- **Back-to-back IF reads with `MEM_LATENCY`=3:** grants at cycles 0, 3, 6 and `rvalid` at cycles 3, 6, 9.
- **Starvation guard:** `MIPS_ARB_STARVE_GUARD_EN` defined, `STARVE_LIMIT`=4, `dm_req` and `if_req` held high. Required: 4 DM grants, then 1 IF grant, repeating. With the macro undefined, no IF grant ever occurs.
- **Reset mid-access:** deassert `rst_n` in a WAIT cycle. Required: no `rvalid`, all outputs 0, and normal grant after release.

Source files
------------

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter
// Shares one single-port unified memory between instruction fetch (IF) and
// data memory (DM). It issues one access at a time, tracks the fixed read
// latency and routes the response back to the port that owns the access.
// DM has priority over IF. The optional starvation guard forces an IF grant
// after STARVE_LIMIT consecutive DM grants while IF waits. The guard is
// enabled by defining the macro MIPS_ARB_STARVE_GUARD_EN.
//
// Ports
//   clk, rst_n                    rising-edge clock, async active-low reset
//   if_req/if_addr                fetch request and address
//   if_gnt/if_rvalid/if_rdata     fetch grant pulse, data valid pulse, data
//   dm_req/dm_we/dm_addr/dm_wdata data request, write flag, address, wdata
//   dm_gnt/dm_rvalid/dm_rdata     data grant pulse, valid/write-done, data
//   mem_en/mem_we/mem_addr/mem_wdata  memory strobe and command, driven
//                                 combinationally from the grant winner
//   mem_rdata                     memory read data, valid MEM_LATENCY cycles
//                                 after mem_en
//   busy                          access outstanding (WAIT state)
module mips_mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 16,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic                  dm_gnt,
    output logic                  dm_rvalid,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [2:0] LAT_LOAD = 3'(MEM_LATENCY - 1);

    state_t                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic                    owner_dm_q, owner_dm_d;
    logic                    owner_we_q, owner_we_d;
    logic [DATA_WIDTH-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0]   dm_rdata_q, dm_rdata_d;

    logic                    resp_s;
    logic                    arb_en_s;
    logic                    if_force_s;
    logic                    gnt_if_s;
    logic                    gnt_dm_s;

    // Response fires when the latency counter has run out; arbitration may
    // reuse that same cycle so back-to-back accesses lose no slot.
    assign resp_s   = (state_q == ST_WAIT) && (cnt_q == 3'd0);
    assign arb_en_s = (state_q == ST_IDLE) || resp_s;

`ifdef MIPS_ARB_STARVE_GUARD_EN
    logic [3:0] starve_q, starve_d;

    assign if_force_s = (starve_q == 4'(STARVE_LIMIT));

    // Count DM grants won while IF is waiting; cleared once IF is served or drops.
    always_comb begin
        starve_d = starve_q;
        if (!if_req) begin
            starve_d = 4'd0;
        end else if (gnt_if_s) begin
            starve_d = 4'd0;
        end else if (gnt_dm_s && (starve_q != 4'hF)) begin
            starve_d = starve_q + 4'd1;
        end else begin
            starve_d = starve_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign if_force_s = 1'b0;
`endif

    // DM wins unless the starvation guard forces a waiting IF through.
    assign gnt_dm_s = arb_en_s && dm_req && !(if_req && if_force_s);
    assign gnt_if_s = arb_en_s && if_req && !gnt_dm_s;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_if_s || gnt_dm_s) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (resp_s && !(gnt_if_s || gnt_dm_s)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: grants, memory command, response routing.
    always_comb begin
        if_gnt    = gnt_if_s;
        dm_gnt    = gnt_dm_s;
        busy      = (state_q == ST_WAIT);
        if_rvalid = resp_s && !owner_dm_q;
        dm_rvalid = resp_s && owner_dm_q;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_dm_s) begin
            mem_en    = 1'b1;
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (gnt_if_s) begin
            mem_en    = 1'b1;
            mem_we    = 1'b0;
            mem_addr  = if_addr;
            mem_wdata = '0;
        end else begin
            mem_en    = 1'b0;
        end
        // rdata passes mem_rdata through on its own rvalid, otherwise holds.
        if (if_rvalid) begin
            if_rdata = mem_rdata;
        end else begin
            if_rdata = if_rdata_q;
        end
        if (dm_rvalid) begin
            dm_rdata = owner_we_q ? {DATA_WIDTH{1'b0}} : mem_rdata;
        end else begin
            dm_rdata = dm_rdata_q;
        end
    end

    // Latency counter, owner and held read data next values.
    always_comb begin
        cnt_d      = cnt_q;
        owner_dm_d = owner_dm_q;
        owner_we_d = owner_we_q;
        if_rdata_d = if_rdata;
        dm_rdata_d = dm_rdata;
        if (gnt_if_s || gnt_dm_s) begin
            cnt_d      = LAT_LOAD;
            owner_dm_d = gnt_dm_s;
            owner_we_d = gnt_dm_s && dm_we;
        end else if (cnt_q != 3'd0) begin
            cnt_d = cnt_q - 3'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= 3'd0;
            owner_dm_q <= 1'b0;
            owner_we_q <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            owner_dm_q <= owner_dm_d;
            owner_we_q <= owner_we_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Testbench for mips_mem_arbiter. Two instances share clock and reset:
// index 0 with MEM_LATENCY=1, index 1 with MEM_LATENCY=3. Each has a small
// memory model whose read data is a fixed function of the address, delayed
// by the latency. Expected responses are queued when a request is driven and
// popped when the matching rvalid appears; a negedge monitor also checks
// grant/command/busy/latency behaviour.
module tb_mips_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        if_req_s    [2];
    logic [31:0] if_addr_s   [2];
    logic        if_gnt_s    [2];
    logic        if_rvalid_s [2];
    logic [15:0] if_rdata_s  [2];
    logic        dm_req_s    [2];
    logic        dm_we_s     [2];
    logic [31:0] dm_addr_s   [2];
    logic [15:0] dm_wdata_s  [2];
    logic        dm_gnt_s    [2];
    logic        dm_rvalid_s [2];
    logic [15:0] dm_rdata_s  [2];
    logic        mem_en_s    [2];
    logic        mem_we_s    [2];
    logic [31:0] mem_addr_s  [2];
    logic [15:0] mem_wdata_s [2];
    logic [15:0] mem_rdata_s [2];
    logic        busy_s      [2];

    mips_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(16), .MEM_LATENCY(1), .STARVE_LIMIT(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req_s[0]), .if_addr(if_addr_s[0]), .if_gnt(if_gnt_s[0]),
        .if_rvalid(if_rvalid_s[0]), .if_rdata(if_rdata_s[0]),
        .dm_req(dm_req_s[0]), .dm_we(dm_we_s[0]), .dm_addr(dm_addr_s[0]),
        .dm_wdata(dm_wdata_s[0]), .dm_gnt(dm_gnt_s[0]), .dm_rvalid(dm_rvalid_s[0]),
        .dm_rdata(dm_rdata_s[0]), .mem_en(mem_en_s[0]), .mem_we(mem_we_s[0]),
        .mem_addr(mem_addr_s[0]), .mem_wdata(mem_wdata_s[0]), .mem_rdata(mem_rdata_s[0]),
        .busy(busy_s[0])
    );

    mips_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(16), .MEM_LATENCY(3), .STARVE_LIMIT(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req_s[1]), .if_addr(if_addr_s[1]), .if_gnt(if_gnt_s[1]),
        .if_rvalid(if_rvalid_s[1]), .if_rdata(if_rdata_s[1]),
        .dm_req(dm_req_s[1]), .dm_we(dm_we_s[1]), .dm_addr(dm_addr_s[1]),
        .dm_wdata(dm_wdata_s[1]), .dm_gnt(dm_gnt_s[1]), .dm_rvalid(dm_rvalid_s[1]),
        .dm_rdata(dm_rdata_s[1]), .mem_en(mem_en_s[1]), .mem_we(mem_we_s[1]),
        .mem_addr(mem_addr_s[1]), .mem_wdata(mem_wdata_s[1]), .mem_rdata(mem_rdata_s[1]),
        .busy(busy_s[1])
    );

    // Memory content model: data at address a is a[15:0] + 0xBEDF (0x10 -> 0xBEEF).
    function automatic logic [15:0] mdata(input logic [31:0] a);
        return a[15:0] + 16'hBEDF;
    endfunction

    logic [31:0] pipe0 = 32'd0;
    logic [31:0] pipe1 [3] = '{32'd0, 32'd0, 32'd0};
    always @(posedge clk) begin
        pipe0    <= mem_addr_s[0];
        pipe1[0] <= mem_addr_s[1];
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end
    assign mem_rdata_s[0] = mdata(pipe0);
    assign mem_rdata_s[1] = mdata(pipe1[2]);

    typedef struct {
        int          k;
        int          port;
        logic [15:0] data;
    } exp_t;
    exp_t sb_q[$];

    int   n_err = 0;
    int   n_chk = 0;
    int   cyc = 0;
    bit   sb_en = 1'b1;
    int   lat_a [2] = '{1, 3};
    int   gnt_cyc [2] = '{0, 0};
    bit   out_k [2] = '{1'b0, 1'b0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic chk_zero(input int k);
        chk("z_if_gnt", {31'd0, if_gnt_s[k]}, 32'd0);
        chk("z_dm_gnt", {31'd0, dm_gnt_s[k]}, 32'd0);
        chk("z_if_rvalid", {31'd0, if_rvalid_s[k]}, 32'd0);
        chk("z_dm_rvalid", {31'd0, dm_rvalid_s[k]}, 32'd0);
        chk("z_if_rdata", {16'd0, if_rdata_s[k]}, 32'd0);
        chk("z_dm_rdata", {16'd0, dm_rdata_s[k]}, 32'd0);
        chk("z_mem_en", {31'd0, mem_en_s[k]}, 32'd0);
        chk("z_mem_we", {31'd0, mem_we_s[k]}, 32'd0);
        chk("z_mem_addr", mem_addr_s[k], 32'd0);
        chk("z_mem_wdata", {16'd0, mem_wdata_s[k]}, 32'd0);
        chk("z_busy", {31'd0, busy_s[k]}, 32'd0);
    endtask

    // Protocol monitor and scoreboard consumer.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                out_k[k] = 1'b0;
            end else begin
                chk("busy", {31'd0, busy_s[k]}, {31'd0, out_k[k]});
                chk("gnt_excl", {31'd0, if_gnt_s[k] & dm_gnt_s[k]}, 32'd0);
                if (if_rvalid_s[k] || dm_rvalid_s[k]) begin
                    int found;
                    int p;
                    found = -1;
                    p = dm_rvalid_s[k] ? 1 : 0;
                    chk("rv_excl", {31'd0, if_rvalid_s[k] & dm_rvalid_s[k]}, 32'd0);
                    chk("rv_outstanding", {31'd0, out_k[k]}, 32'd1);
                    chk("rv_latency", cyc - gnt_cyc[k], lat_a[k]);
                    if (sb_en) begin
                        for (int i = 0; i < sb_q.size(); i++) begin
                            if (found < 0 && sb_q[i].k == k && sb_q[i].port == p) found = i;
                        end
                        if (found < 0) begin
                            chk("sb_unexpected", 32'd1, 32'd0);
                        end else begin
                            if (p == 1) chk("dm_rdata", {16'd0, dm_rdata_s[k]}, {16'd0, sb_q[found].data});
                            else        chk("if_rdata", {16'd0, if_rdata_s[k]}, {16'd0, sb_q[found].data});
                            sb_q.delete(found);
                        end
                    end
                    out_k[k] = 1'b0;
                end
                if (dm_gnt_s[k]) begin
                    chk("dm_mem_en", {31'd0, mem_en_s[k]}, 32'd1);
                    chk("dm_mem_we", {31'd0, mem_we_s[k]}, {31'd0, dm_we_s[k]});
                    chk("dm_mem_addr", mem_addr_s[k], dm_addr_s[k]);
                    if (dm_we_s[k]) chk("dm_mem_wdata", {16'd0, mem_wdata_s[k]}, {16'd0, dm_wdata_s[k]});
                    gnt_cyc[k] = cyc;
                    out_k[k] = 1'b1;
                end else if (if_gnt_s[k]) begin
                    chk("if_mem_en", {31'd0, mem_en_s[k]}, 32'd1);
                    chk("if_mem_we", {31'd0, mem_we_s[k]}, 32'd0);
                    chk("if_mem_addr", mem_addr_s[k], if_addr_s[k]);
                    gnt_cyc[k] = cyc;
                    out_k[k] = 1'b1;
                end else begin
                    chk("idle_mem_en", {31'd0, mem_en_s[k]}, 32'd0);
                    chk("idle_mem_addr", mem_addr_s[k], 32'd0);
                end
            end
        end
    end

    // Drive one request on port (0=IF, 1=DM) of instance k; returns grant cycle.
    task automatic issue(input int k, input int port, input logic we, input logic [31:0] addr,
                         input logic [15:0] wd, output int gc);
        exp_t e;
        int   n;
        bit   seen;
        e.k = k;
        e.port = port;
        e.data = (port == 1 && we) ? 16'h0000 : mdata(addr);
        sb_q.push_back(e);
        if (port == 0) begin
            if_addr_s[k] = addr;
            if_req_s[k]  = 1'b1;
        end else begin
            dm_addr_s[k]  = addr;
            dm_we_s[k]    = we;
            dm_wdata_s[k] = wd;
            dm_req_s[k]   = 1'b1;
        end
        n = 0;
        seen = 1'b0;
        gc = -1;
        while (!seen && n < 50) begin
            @(negedge clk);
            seen = (port == 0) ? if_gnt_s[k] : dm_gnt_s[k];
            n++;
        end
        if (!seen) chk("gnt_timeout", 32'd0, 32'd1);
        else gc = cyc;
        @(posedge clk);
        #1;
        if (port == 0) if_req_s[k] = 1'b0;
        else dm_req_s[k] = 1'b0;
    endtask

    initial begin
        int g0, g1, g2, gi, gd, n;
        bit exp_if;
        for (int k = 0; k < 2; k++) begin
            if_req_s[k] = 1'b0; if_addr_s[k] = 32'd0;
            dm_req_s[k] = 1'b0; dm_we_s[k] = 1'b0; dm_addr_s[k] = 32'd0; dm_wdata_s[k] = 16'd0;
        end
        repeat (3) @(negedge clk);
        chk_zero(0);
        chk_zero(1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single IF read, latency 1.
        issue(0, 0, 1'b0, 32'h10, 16'h0, g0);
        // DM read then DM write: dm_rdata goes non-zero then back to 0.
        issue(0, 1, 1'b0, 32'h40, 16'h0, g0);
        issue(0, 1, 1'b1, 32'h20, 16'h1234, g0);
        @(negedge clk);
        chk("if_rdata_hold", {16'd0, if_rdata_s[0]}, 32'h0000BEEF);
        @(posedge clk); #1;

        // Simultaneous requests on both instances.
        for (int k = 0; k < 2; k++) begin
            fork
                issue(k, 0, 1'b0, 32'h50, 16'h0, gi);
                issue(k, 1, 1'b0, 32'h60, 16'h0, gd);
            join
            chk("sim_order", gi - gd, lat_a[k]);
            repeat (4) @(negedge clk);
            chk("dm_rdata_hold", {16'd0, dm_rdata_s[k]}, {16'd0, mdata(32'h60)});
            @(posedge clk); #1;
        end

        // Back-to-back IF reads, latency 3.
        issue(1, 0, 1'b0, 32'h100, 16'h0, g0);
        issue(1, 0, 1'b0, 32'h104, 16'h0, g1);
        issue(1, 0, 1'b0, 32'h108, 16'h0, g2);
        chk("b2b_gap1", g1 - g0, 32'd3);
        chk("b2b_gap2", g2 - g1, 32'd3);
        repeat (4) @(posedge clk);
        #1;

        // Starvation: both requests held on instance 0.
        sb_en = 1'b0;
        if_addr_s[0] = 32'h200; dm_addr_s[0] = 32'h300; dm_we_s[0] = 1'b0;
        if_req_s[0] = 1'b1; dm_req_s[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
`ifdef MIPS_ARB_STARVE_GUARD_EN
            exp_if = ((i % 5) == 4);
`else
            exp_if = 1'b0;
`endif
            chk("starve_if_gnt", {31'd0, if_gnt_s[0]}, {31'd0, exp_if});
            chk("starve_dm_gnt", {31'd0, dm_gnt_s[0]}, {31'd0, !exp_if});
        end
        @(posedge clk); #1;
        if_req_s[0] = 1'b0; dm_req_s[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        sb_en = 1'b1;

        // Reset in the middle of a latency-3 access.
        if_addr_s[1] = 32'h70;
        if_req_s[1] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if_gnt_s[1] && n < 50);
        chk("rst_gnt_seen", {31'd0, if_gnt_s[1]}, 32'd1);
        @(posedge clk); #1;
        if_req_s[1] = 1'b0;
        @(negedge clk);
        chk("rst_busy_before", {31'd0, busy_s[1]}, 32'd1);
        #1;
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk_zero(1);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        issue(1, 1, 1'b0, 32'h80, 16'h0, g0);
        issue(1, 0, 1'b0, 32'h84, 16'h0, g0);

        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("sb_drain", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
